prime_sieve_collector: RTL and testbench

Controller and result collector on the far side of the prime counter array. It sweeps a candidate number upward from 2 to a latched search limit, steps the prime counters in lockstep with the candidate, and reads back their terminal-count (hit) vector. Any hit marks the candidate composite; otherwise it is recorded as prime. It reports the largest prime found, the prime count and the elapsed cycle count, with a start/busy/done handshake toward the top-level control.

---
 rtl/prime_sieve_collector.sv | 160 ++++++++++++++++
 tb/tb_prime_sieve_collector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prime_sieve_collector.sv
// -----------------------------------------------------------------------------
// prime_sieve_collector
//
// Sweeps a candidate number from 2 up to a latched search limit while stepping
// the external prime counter array in lockstep. A candidate with no counter
// hit is prime; the block keeps the largest prime seen, the prime count and a
// saturating count of cycles spent clearing and scanning.
//
// Ports
//   Clock          in   system clock, rising edge
//   Reset_n        in   asynchronous active-low reset
//   Start          in   begin a search (honoured in IDLE or DONE only)
//   SearchLimit    in   inclusive upper bound, latched on an accepted Start
//   Pause          in   freeze the scan while high (timer keeps running)
//   CounterHit     in   per-counter hit: Candidate is a proper multiple of it
//   CounterClear   out  one-cycle clear to every counter (CLEAR state)
//   CounterEnable  out  per-counter advance strobe (unpaused SCAN)
//   Candidate      out  number currently under test
//   Busy           out  high in CLEAR and SCAN
//   Done           out  high in DONE
//   LargestPrime   out  largest prime found in the current/last run
//   PrimeCount     out  primes found in the current/last run
//   ElapsedCycles  out  CLEAR+SCAN cycles of the run, saturating
// -----------------------------------------------------------------------------
module prime_sieve_collector #(
    parameter int NUM_COUNTERS  = 10,
    parameter int COUNTER_WIDTH = 20,
    parameter int TIMER_WIDTH   = 32
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     Start,
    input  logic [COUNTER_WIDTH-1:0] SearchLimit,
    input  logic                     Pause,
    input  logic [NUM_COUNTERS-1:0]  CounterHit,
    output logic                     CounterClear,
    output logic [NUM_COUNTERS-1:0]  CounterEnable,
    output logic [COUNTER_WIDTH-1:0] Candidate,
    output logic                     Busy,
    output logic                     Done,
    output logic [COUNTER_WIDTH-1:0] LargestPrime,
    output logic [COUNTER_WIDTH-1:0] PrimeCount,
    output logic [TIMER_WIDTH-1:0]   ElapsedCycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } sieveState_t;

    sieveState_t state;
    sieveState_t nextState;

    logic [COUNTER_WIDTH-1:0] limitReg;
    logic                     startAccept;
    logic                     limitTooSmall;
    logic                     lastCandidate;
    logic                     isPrime;
    logic [TIMER_WIDTH-1:0]   elapsedNext;

    // Start is only meaningful when no run is in flight.
    assign startAccept   = Start && ((state == IDLE) || (state == DONE));
    assign limitTooSmall = SearchLimit < COUNTER_WIDTH'(2);
    assign lastCandidate = (Candidate == limitReg);
    // Hits refer to the present Candidate, so no hit means no smaller prime divides it.
    assign isPrime       = (CounterHit == '0);
    assign elapsedNext   = (ElapsedCycles == '1) ? ElapsedCycles
                                                 : ElapsedCycles + TIMER_WIDTH'(1);

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and control strobes
    always_comb begin
        nextState     = state;
        CounterClear  = 1'b0;
        CounterEnable = '0;
        Busy          = 1'b0;
        Done          = 1'b0;
        case (state)
            IDLE: begin
                if (startAccept) begin
                    nextState = limitTooSmall ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                Busy         = 1'b1;
                CounterClear = 1'b1;
                nextState    = SCAN;
            end
            SCAN: begin
                Busy = 1'b1;
                if (!Pause) begin
                    // Counters advance on the same edge as Candidate.
                    CounterEnable = '1;
                    if (lastCandidate) begin
                        nextState = DONE;
                    end
                end
            end
            DONE: begin
                Done = 1'b1;
                if (startAccept) begin
                    nextState = limitTooSmall ? DONE : CLEAR;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: limit latch, candidate sweep, result collection, timer
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            limitReg      <= '0;
            Candidate     <= '0;
            LargestPrime  <= '0;
            PrimeCount    <= '0;
            ElapsedCycles <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (startAccept) begin
                        limitReg      <= SearchLimit;
                        Candidate     <= '0;
                        LargestPrime  <= '0;
                        PrimeCount    <= '0;
                        ElapsedCycles <= '0;
                    end
                end
                CLEAR: begin
                    Candidate     <= COUNTER_WIDTH'(2);
                    ElapsedCycles <= TIMER_WIDTH'(1);
                end
                SCAN: begin
                    ElapsedCycles <= elapsedNext;
                    if (!Pause) begin
                        if (isPrime) begin
                            LargestPrime <= Candidate;
                            PrimeCount   <= PrimeCount + COUNTER_WIDTH'(1);
                        end
                        // Hold at the limit rather than stepping past it.
                        if (!lastCandidate) begin
                            Candidate <= Candidate + COUNTER_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_sieve_collector.sv
module tb_prime_sieve_collector;

    localparam int NC = 10;
    localparam int CW = 20;
    localparam int TW = 32;

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic          Pause = 1'b0;
    logic [CW-1:0] SearchLimit = '0;
    logic [NC-1:0] CounterHit;
    logic          CounterClear;
    logic [NC-1:0] CounterEnable;
    logic [CW-1:0] Candidate;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] LargestPrime;
    logic [CW-1:0] PrimeCount;
    logic [TW-1:0] ElapsedCycles;

    int checks = 0;
    int errors = 0;

    // Counter array model: each counter tracks the value it has been stepped
    // to and flags a hit when that value is a proper multiple of its prime.
    int primeTab[NC];
    int cnt[NC];

    always #5 Clock = ~Clock;

    prime_sieve_collector #(
        .NUM_COUNTERS (NC),
        .COUNTER_WIDTH(CW),
        .TIMER_WIDTH  (TW)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .SearchLimit  (SearchLimit),
        .Pause        (Pause),
        .CounterHit   (CounterHit),
        .CounterClear (CounterClear),
        .CounterEnable(CounterEnable),
        .Candidate    (Candidate),
        .Busy         (Busy),
        .Done         (Done),
        .LargestPrime (LargestPrime),
        .PrimeCount   (PrimeCount),
        .ElapsedCycles(ElapsedCycles)
    );

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NC; i++) cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (CounterClear) cnt[i] <= 2;
                else if (CounterEnable[i]) cnt[i] <= cnt[i] + 1;
            end
        end
    end

    always_comb begin
        CounterHit = '0;
        for (int i = 0; i < NC; i++) begin
            if (primeTab[i] != 0)
                CounterHit[i] = (cnt[i] % primeTab[i] == 0) && (cnt[i] != primeTab[i]);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain trial division over 2..lim.
    function automatic void refSieve(input int lim, output int largest, output int count);
        largest = 0;
        count   = 0;
        for (int n = 2; n <= lim; n++) begin
            bit prime = 1'b1;
            for (int d = 2; d * d <= n; d++) if (n % d == 0) prime = 1'b0;
            if (prime) begin
                largest = n;
                count++;
            end
        end
    endfunction

    // Called #1 after a rising edge. Optional pause of pauseLen cycles when
    // Candidate reaches pauseCand; optional Start pulse (limit midLim) when
    // Candidate reaches 5 mid-run.
    task automatic runSearch(input int lim, input int pauseCand, input int pauseLen, input int midLim);
        int  cyc, pauseLeft, expL, expC, expLat, expEl, enBad, holdBad;
        bit  midFired;
        refSieve(lim, expL, expC);
        expLat = (lim < 2) ? 1 : lim + 1 + pauseLen;
        expEl  = (lim < 2) ? 0 : lim + pauseLen;
        SearchLimit = CW'(lim);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        SearchLimit = CW'($urandom_range(0, 1000));
        chk("clearAfterStart", CounterClear, (lim >= 2) ? 1 : 0);
        chk("busyAfterStart", Busy, (lim >= 2) ? 1 : 0);
        cyc = 1; pauseLeft = pauseLen; enBad = 0; holdBad = 0; midFired = 1'b0;
        while (!Done && cyc < 5000) begin
            Pause = 1'b0;
            Start = 1'b0;
            if (Busy && !CounterClear && pauseLeft > 0 && Candidate == CW'(pauseCand)) begin
                Pause = 1'b1;
                pauseLeft--;
            end
            if (Busy && midLim >= 0 && !midFired && Candidate == CW'(5)) begin
                Start = 1'b1;
                SearchLimit = CW'(midLim);
                midFired = 1'b1;
            end
            @(negedge Clock);
            if (Busy && !CounterClear) begin
                if (Pause) begin
                    if (CounterEnable != '0 || Candidate != CW'(pauseCand)) holdBad++;
                end else if (CounterEnable != '1) begin
                    enBad++;
                end
            end
            @(posedge Clock); #1;
            cyc++;
        end
        Pause = 1'b0;
        Start = 1'b0;
        chk("latency", cyc, expLat);
        chk("largest", LargestPrime, expL);
        chk("count", PrimeCount, expC);
        chk("elapsed", ElapsedCycles, expEl);
        chk("busyAtDone", Busy, 0);
        chk("enableScan", enBad, 0);
        chk("pauseHold", holdBad, 0);
        repeat (3) @(posedge Clock);
        #1;
        chk("holdLargest", LargestPrime, expL);
        chk("holdCount", PrimeCount, expC);
        chk("holdDone", Done, 1);
        chk("holdEnable", CounterEnable, 0);
    endtask

    initial begin
        int w;
        primeTab = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
        #1;
        chk("rstCandidate", Candidate, 0);
        chk("rstLargest", LargestPrime, 0);
        chk("rstCount", PrimeCount, 0);
        chk("rstElapsed", ElapsedCycles, 0);
        chk("rstBusy", Busy, 0);
        chk("rstDone", Done, 0);
        chk("rstClear", CounterClear, 0);
        chk("rstEnable", CounterEnable, 0);
        #11 Reset_n = 1'b1;
        @(posedge Clock); #1;

        primeTab = '{2, 3, 5, 7, 0, 0, 0, 0, 0, 0};
        runSearch(10, 0, 0, -1);
        primeTab = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
        runSearch(30, 0, 0, -1);
        runSearch(1, 0, 0, -1);
        runSearch(0, 0, 0, -1);
        runSearch(2, 0, 0, -1);
        runSearch(20, 11, 5, -1);
        runSearch(20, 0, 0, 5);

        // Asynchronous reset in the middle of a scan
        SearchLimit = CW'(20);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        w = 0;
        while (Candidate != CW'(9) && w < 100) begin
            @(posedge Clock); #1;
            w++;
        end
        chk("reachNine", Candidate, 9);
        #2 Reset_n = 1'b0;
        #1;
        chk("midRstCandidate", Candidate, 0);
        chk("midRstLargest", LargestPrime, 0);
        chk("midRstCount", PrimeCount, 0);
        chk("midRstElapsed", ElapsedCycles, 0);
        chk("midRstBusy", Busy, 0);
        chk("midRstEnable", CounterEnable, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        runSearch(10, 0, 0, -1);

        for (int r = 0; r < 8; r++) begin
            int lim, pl, pc, ml;
            lim = $urandom_range(0, 60);
            pl  = $urandom_range(0, 4);
            pc  = (lim >= 2) ? $urandom_range(2, lim) : 0;
            ml  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : -1;
            runSearch(lim, pc, pl, ml);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
